// File: rtl/drsstc_pkg.sv
// Shared types and elaboration-time helpers for the DRSSTC drive path.
package drsstc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2,
    FAULT = 2'd3
  } burst_state_t;

  // Smallest r such that 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = unsigned'(i + 1);
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width needed to hold the longest burst, in clocks.
  function automatic int unsigned on_clk_w(input int unsigned clk_mhz,
                                           input int unsigned max_on_us);
    return clog2(max_on_us * clk_mhz + 1);
  endfunction

  // Width needed to hold the longest off-time, in clocks.
  function automatic int unsigned off_clk_w(input int unsigned clk_mhz,
                                            input int unsigned max_on_us,
                                            input int unsigned off_ratio);
    return clog2(max_on_us * clk_mhz * off_ratio + 1);
  endfunction

endpackage

// File: rtl/burst_sched_if.sv
// Interrupter-side bus of the burst scheduler: request inputs and gate/status outputs.
interface burst_sched_if;
  logic       en;
  logic       trig;
  logic [7:0] on_us;
  logic       fault;
  logic       gate;
  logic       pwm_rst;
  logic       busy;
  logic       fault_latched;

  // Driver side (interrupter / OCD comparator / stimulus).
  modport master (
    output en, trig, on_us, fault,
    input  gate, pwm_rst, busy, fault_latched
  );

  // Scheduler side.
  modport slave (
    input  en, trig, on_us, fault,
    output gate, pwm_rst, busy, fault_latched
  );
endinterface

// File: rtl/edge_rise.sv
// Rising-edge detector: o_rise is high in the cycle where i_d is 1 and was 0 a cycle earlier.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_d_q;

  // Delayed copy of the input, updated every cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (rst) r_d_q <= 1'b0;
    else     r_d_q <= i_d;
  end

  assign o_rise = i_d & ~r_d_q;

endmodule

// File: rtl/burst_sched.sv
// Burst scheduler: turns interrupter trigger edges into bounded gate windows,
// enforces a proportional off-time after each burst and latches faults with a hold-off.
module burst_sched
  import drsstc_pkg::*;
#(
  parameter int unsigned CLK_MHZ       = 50,
  parameter int unsigned MAX_ON_US     = 100,
  parameter int unsigned OFF_RATIO     = 4,
  parameter int unsigned FAULT_HOLD_US = 10
) (
  input  logic          clk,
  input  logic          rst,
  burst_sched_if.slave  bus
);

  // Counter must cover the longest off-time and the fault hold-off.
  localparam int unsigned CNT_W = max_u(off_clk_w(CLK_MHZ, MAX_ON_US, OFF_RATIO),
                                        clog2(FAULT_HOLD_US * CLK_MHZ));
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_ON_C  = CNT_W'(MAX_ON_US);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(FAULT_HOLD_US * CLK_MHZ - 1);

  burst_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_gate, r_pwm_rst, r_busy, r_fault_latched;

  logic             w_rise;
  logic [CNT_W-1:0] w_on_req, w_on_eff, w_on_clk, w_off_clk;

  edge_rise u_trig_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.trig),
    .o_rise (w_rise)
  );

  // Clamp first, then scale to clocks; CNT_W holds both products without truncation.
  assign w_on_req  = CNT_W'(bus.on_us);
  assign w_on_eff  = (w_on_req > MAX_ON_C) ? MAX_ON_C : w_on_req;
  assign w_on_clk  = w_on_eff * CNT_W'(CLK_MHZ);
  assign w_off_clk = w_on_clk * CNT_W'(OFF_RATIO);

  // Next-state and counter logic; fault takes priority over every other transition.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.fault) begin
          w_state_nxt = FAULT;
          w_cnt_nxt   = HOLD_LOAD;
        end else if (w_rise && bus.en && (bus.on_us != 8'd0)) begin
          w_state_nxt = ON;
          w_cnt_nxt   = w_on_clk - ONE;
        end
      end
      ON: begin
        if (bus.fault) begin
          w_state_nxt = FAULT;
          w_cnt_nxt   = HOLD_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = OFF;
          w_cnt_nxt   = w_off_clk - ONE;
        end else begin
          w_cnt_nxt   = r_cnt - ONE;
        end
      end
      OFF: begin
        if (bus.fault) begin
          w_state_nxt = FAULT;
          w_cnt_nxt   = HOLD_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - ONE;
        end
      end
      FAULT: begin
        // Counter parks at zero while the fault input is still asserted.
        if (r_cnt == '0) begin
          if (!bus.fault) w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_gate          <= 1'b0;
      r_pwm_rst       <= 1'b1;
      r_busy          <= 1'b0;
      r_fault_latched <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_gate          <= (w_state_nxt == ON);
      r_pwm_rst       <= (w_state_nxt != ON);
      r_busy          <= (w_state_nxt != IDLE);
      r_fault_latched <= (w_state_nxt == FAULT);
    end
  end

  assign bus.gate          = r_gate;
  assign bus.pwm_rst       = r_pwm_rst;
  assign bus.busy          = r_busy;
  assign bus.fault_latched = r_fault_latched;

endmodule

// File: tb/tb_burst_sched.sv
// Directed bench for burst_sched with default parameters (50 MHz, 100 us cap, ratio 4, 10 us hold).
module tb_burst_sched;
  import drsstc_pkg::*;

  localparam int BOUND = 30000;

  logic clk;
  logic rst;
  int   n_err;
  int   n_checks;

  burst_sched_if bus ();

  burst_sched #(
    .CLK_MHZ       (50),
    .MAX_ON_US     (100),
    .OFF_RATIO     (4),
    .FAULT_HOLD_US (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a clean rising trig edge; on return the edge has been sampled.
  task automatic fire(input logic [7:0] us);
    bus.trig  = 1'b0;
    bus.on_us = us;
    step();
    bus.trig = 1'b1;
    step();
    bus.trig = 1'b0;
  endtask

  // Step until busy drops, counting gate/busy samples; optionally toggle trig every 'toggle' cycles.
  task automatic run_burst(input int toggle, output int n_gate, output int n_busy,
                           output int pwm_bad, output bit timeout);
    n_gate  = 0;
    n_busy  = 0;
    pwm_bad = 0;
    timeout = 1'b1;
    for (int c = 0; c < BOUND; c++) begin
      if (bus.pwm_rst !== ~bus.gate) pwm_bad++;
      if (bus.busy !== 1'b1) begin
        timeout = 1'b0;
        break;
      end
      if (bus.gate === 1'b1) n_gate++;
      n_busy++;
      if (toggle != 0 && c != 0 && (c % toggle) == 0) bus.trig = ~bus.trig;
      step();
    end
    bus.trig = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.trig  = 1'b0;
    bus.on_us = 8'd0;
    bus.fault = 1'b0;
    repeat (3) step();
    n_checks++; if (bus.gate !== 1'b0)          begin n_err++; $display("FAIL reset_gate got=%b exp=0", bus.gate); end
    n_checks++; if (bus.pwm_rst !== 1'b1)       begin n_err++; $display("FAIL reset_pwm_rst got=%b exp=1", bus.pwm_rst); end
    n_checks++; if (bus.busy !== 1'b0)          begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.fault_latched !== 1'b0) begin n_err++; $display("FAIL reset_fault_latched got=%b exp=0", bus.fault_latched); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    int ng, nb, pb;
    bit to;
    bus.en = 1'b1;
    fire(8'd10);
    n_checks++; if (bus.gate !== 1'b1) begin n_err++; $display("FAIL nominal_first_gate got=%b exp=1", bus.gate); end
    run_burst(0, ng, nb, pb, to);
    n_checks++; if (to)        begin n_err++; $display("FAIL nominal_timeout got=busy exp=idle"); end
    n_checks++; if (ng != 500) begin n_err++; $display("FAIL nominal_gate_width got=%0d exp=500", ng); end
    n_checks++; if (nb != 2500) begin n_err++; $display("FAIL nominal_busy_width got=%0d exp=2500", nb); end
    n_checks++; if (pb != 0)   begin n_err++; $display("FAIL nominal_pwm_rst got=%0d bad exp=0", pb); end
  endtask

  task automatic test_clamp();
    int ng, nb, pb;
    bit to;
    fire(8'd200);
    run_burst(0, ng, nb, pb, to);
    n_checks++; if (to)          begin n_err++; $display("FAIL clamp_timeout got=busy exp=idle"); end
    n_checks++; if (ng != 5000)  begin n_err++; $display("FAIL clamp_gate_width got=%0d exp=5000", ng); end
    n_checks++; if (nb != 25000) begin n_err++; $display("FAIL clamp_busy_width got=%0d exp=25000", nb); end
  endtask

  task automatic test_drop();
    int seen;
    fire(8'd0);
    seen = 0;
    repeat (5) begin
      if (bus.gate !== 1'b0 || bus.busy !== 1'b0) seen++;
      step();
    end
    n_checks++; if (seen != 0) begin n_err++; $display("FAIL zero_request got=%0d active exp=0", seen); end
    bus.en = 1'b0;
    fire(8'd10);
    seen = 0;
    repeat (5) begin
      if (bus.gate !== 1'b0 || bus.busy !== 1'b0) seen++;
      step();
    end
    n_checks++; if (seen != 0) begin n_err++; $display("FAIL disabled_trigger got=%0d active exp=0", seen); end
    bus.en = 1'b1;
  endtask

  task automatic test_lockout();
    int ng, nb, pb;
    bit to;
    fire(8'd10);
    run_burst(50, ng, nb, pb, to);
    n_checks++; if (ng != 500 || nb != 2500 || to) begin
      n_err++; $display("FAIL lockout_widths got=%0d/%0d exp=500/2500", ng, nb);
    end
    fire(8'd10);
    n_checks++; if (bus.gate !== 1'b1) begin n_err++; $display("FAIL lockout_rearm got=%b exp=1", bus.gate); end
    run_burst(0, ng, nb, pb, to);
    n_checks++; if (ng != 500) begin n_err++; $display("FAIL lockout_next_width got=%0d exp=500", ng); end
  endtask

  task automatic test_fault_on();
    int nf;
    fire(8'd10);
    repeat (100) step();
    bus.fault = 1'b1;
    step();
    bus.fault = 1'b0;
    n_checks++; if (bus.gate !== 1'b0 || bus.fault_latched !== 1'b1) begin
      n_err++; $display("FAIL fault_on_entry got=gate%b/flt%b exp=gate0/flt1", bus.gate, bus.fault_latched);
    end
    nf = 0;
    while (bus.fault_latched === 1'b1 && nf < BOUND) begin
      nf++;
      step();
    end
    n_checks++; if (nf != 500) begin n_err++; $display("FAIL fault_hold_width got=%0d exp=500", nf); end
    n_checks++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL fault_exit_idle got=%b exp=0", bus.busy); end

    fire(8'd10);
    repeat (100) step();
    bus.fault = 1'b1;
    repeat (2000) step();
    n_checks++; if (bus.fault_latched !== 1'b1) begin n_err++; $display("FAIL fault_held got=%b exp=1", bus.fault_latched); end
    bus.fault = 1'b0;
    step();
    n_checks++; if (bus.fault_latched !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL fault_release got=flt%b/busy%b exp=0/0", bus.fault_latched, bus.busy);
    end
  endtask

  task automatic test_fault_expiry();
    int nf;
    fire(8'd10);
    repeat (499) step();
    n_checks++; if (bus.gate !== 1'b1) begin n_err++; $display("FAIL expiry_last_on got=%b exp=1", bus.gate); end
    bus.fault = 1'b1;
    step();
    bus.fault = 1'b0;
    n_checks++; if (bus.fault_latched !== 1'b1 || bus.gate !== 1'b0) begin
      n_err++; $display("FAIL expiry_fault_wins got=flt%b/gate%b exp=1/0", bus.fault_latched, bus.gate);
    end
    nf = 0;
    while (bus.busy === 1'b1 && nf < BOUND) begin
      nf++;
      step();
    end
    n_checks++; if (nf != 500) begin n_err++; $display("FAIL expiry_fault_len got=%0d exp=500", nf); end

    bus.on_us = 8'd10;
    bus.trig  = 1'b0;
    step();
    bus.trig  = 1'b1;
    bus.fault = 1'b1;
    step();
    bus.trig  = 1'b0;
    bus.fault = 1'b0;
    n_checks++; if (bus.gate !== 1'b0 || bus.fault_latched !== 1'b1) begin
      n_err++; $display("FAIL idle_fault_priority got=gate%b/flt%b exp=0/1", bus.gate, bus.fault_latched);
    end
    nf = 0;
    while (bus.busy === 1'b1 && nf < BOUND) begin
      nf++;
      step();
    end
    n_checks++; if (nf != 500) begin n_err++; $display("FAIL idle_fault_len got=%0d exp=500", nf); end
  endtask

  task automatic test_reset_mid();
    int ng, nb, pb;
    bit to;
    fire(8'd10);
    repeat (200) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus.gate !== 1'b0 || bus.pwm_rst !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_mid got=gate%b/pwm_rst%b/busy%b exp=0/1/0", bus.gate, bus.pwm_rst, bus.busy);
    end
    step();
    bus.trig = 1'b1;
    step();
    bus.trig = 1'b0;
    n_checks++; if (bus.gate !== 1'b1) begin n_err++; $display("FAIL reset_restart got=%b exp=1", bus.gate); end
    run_burst(0, ng, nb, pb, to);
    n_checks++; if (ng != 500 || nb != 2500 || to) begin
      n_err++; $display("FAIL reset_restart_widths got=%0d/%0d exp=500/2500", ng, nb);
    end
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    test_reset();
    test_nominal();
    test_clamp();
    test_drop();
    test_lockout();
    test_fault_on();
    test_fault_expiry();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/burst_sched.md
Name: burst_sched

Overview:
- Burst scheduler (interrupter) for the DRSSTC drive path.
- Turns external interrupter trigger edges into bounded "gate" windows that enable the fixed-frequency PWM generator.
- Limits maximum on-time, enforces a duty-limiting off-time after every burst, and latches over-current faults with a hold-off.
- Sits between the interrupter input / OCD comparator and the pwm block. The pwm block's rst is driven from pwm_rst.

Parameters:
- CLK_MHZ, 50: system clock frequency in MHz.
- MAX_ON_US, 100: on-time ceiling in us. Requested on-time is clamped to this.
- OFF_RATIO, 4: mandatory off-time after a burst = OFF_RATIO × actual on-time. Integer ≥ 1.
- FAULT_HOLD_US, 10: minimum FAULT dwell in us before recovery is allowed.

Ports:
- clk  in  1: system clock. Single clock domain.
- rst  in  1: synchronous, active-high reset.
- en  in  1: global enable. While 0, new triggers are ignored.
- trig  in  1: interrupter request, already synchronous to clk. Rising edge starts a burst.
- on_us  in  8: requested on-time in us. Sampled on the accepted trigger edge.
- fault  in  1: over-current / fault input, active-high, level-sensitive.
- gate  out  1: burst window. High = PWM allowed to run.
- pwm_rst  out  1: reset for the pwm block. Registered; equals !gate.
- busy  out  1: high in ON, OFF and FAULT.
- fault_latched  out  1: high while in FAULT.

Behaviour:
- One clock domain, no combinational input-to-output paths. All outputs are registered.
- Reset values: gate=0, pwm_rst=1, busy=0, fault_latched=0, state=IDLE, counter=0, trig_q=0.
- Edge detect: rise = trig & !trig_q, where trig_q is a 1-cycle delayed copy of trig. trig_q updates every cycle, in all states.
- Clamp: on_eff = min(on_us, MAX_ON_US). on_clk = on_eff × CLK_MHZ. off_clk = on_clk × OFF_RATIO.
- Counter width: clog2(MAX_ON_US × CLK_MHZ × OFF_RATIO + 1).
- States: IDLE, ON, OFF, FAULT.
- IDLE:
  - fault=1 has priority over any trigger: go to FAULT.
  - else rise & en & (on_us != 0): go to ON and load counter = on_clk − 1.
  - else stay. Triggers with on_us=0 or en=0 are dropped, not queued.
- ON:
  - gate=1 from the cycle after the accepted edge, for exactly on_clk cycles.
  - Counter decrements each cycle. At counter==0, go to OFF with counter = off_clk − 1.
  - fault=1 in any ON cycle: go to FAULT. gate drops on the next edge. Fault wins over counter expiry in the same cycle.
  - en falling during ON does not shorten the burst.
- OFF:
  - gate=0 for exactly off_clk cycles, then IDLE.
  - fault=1 in OFF: go to FAULT.
- FAULT:
  - gate=0, fault_latched=1. Counter loads FAULT_HOLD_US × CLK_MHZ − 1 on entry.
  - Go to IDLE only when counter==0 and fault==0. If fault is still high at expiry, stay in FAULT with counter held at 0.
  - Exit is to IDLE, not OFF.
- Trigger edges during ON, OFF and FAULT are ignored. There is no queuing or retrigger extension.
- rst asserted mid-burst: on the next edge gate=0, pwm_rst=1, state=IDLE. Fault latch clears.
- Arithmetic: products are computed at full width, with no truncation. Clamp is applied before multiplication.

Decomposition:
- Package drsstc_pkg holds:
  - state enum burst_state_t {IDLE, ON, OFF, FAULT};
  - localparam functions for on_clk / off_clk widths;
  - the shared clog2/div helpers used by the other blocks.
- One sub-module, edge_rise: registered rising-edge detector with sync reset. Reused for trig.
- Counter and FSM stay in burst_sched.

Test Plan:
- Defaults apply throughout (CLK_MHZ=50, MAX_ON_US=100, OFF_RATIO=4, FAULT_HOLD_US=10).
- Nominal burst: en=1, on_us=10, trig rises at cycle T → gate=1 on cycles T+1..T+500; busy=1 through T+2500; IDLE at T+2501; pwm_rst always equals !gate.
- Clamp and zero request: on_us=200 → gate high for exactly 5000 cycles, then off 20000. on_us=0 or en=0 with a trig edge → no gate, busy stays 0.
- Retrigger lockout: trig toggled every 50 cycles during ON and OFF of a 10 us burst → gate width stays 500 cycles; next burst only on the first edge after return to IDLE.
- Fault in ON: fault pulses high for 1 cycle at 100 cycles into ON → gate=0 next cycle, fault_latched=1 for 500 cycles, then IDLE. Fault held high 2000 cycles → FAULT persists until the cycle after fault falls.
- Fault vs expiry: fault asserted on the final ON cycle → state goes to FAULT, not OFF. Fault asserted simultaneously with a trig edge in IDLE → FAULT, no gate.
- Reset mid-operation: rst pulsed 1 cycle at 200 cycles into ON → gate=0, pwm_rst=1, busy=0 next edge; a new trig edge 1 cycle after rst release starts a full 500-cycle burst.
